// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_framer
// Description : GMII transmit framer. Wraps a client byte stream with
//               preamble and SFD, adds optional zero pad and CRC-32 FCS, and
//               enforces the inter-frame gap. An underrun aborts the frame
//               with a single error-marked byte.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_FRAME    = 60,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  input  logic                 tx_last,
  output logic                 tx_ready,
  input  logic                 crc_en,
  input  logic                 pad_en,
  output logic [7:0]           gmii_tx_d,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  output logic                 frame_done,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_ABORT    = 3'd6,
    ST_IFG      = 3'd7
  } state_t;

  localparam logic [7:0]           c_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]           c_SFD_BYTE      = 8'hD5;
  localparam logic [31:0]          c_CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0]          c_CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [15:0]          c_BYTE_CNT_MAX  = 16'hFFFF;
  localparam logic [15:0]          c_MIN_FRAME     = 16'(MIN_FRAME);
  localparam logic [7:0]           c_PRE_LAST      = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]           c_IFG_LAST      = 8'(IFG_BYTES - 1);
  localparam logic [7:0]           c_FCS_LAST      = 8'd3;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE       = CNT_WIDTH'(1);

  // One byte of the reflected CRC-32 (LSB-first shift register)
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_tick;          // cycles spent in the current state
  logic [15:0] r_byte_cnt;      // payload + pad bytes, saturating
  logic [15:0] w_cnt_plus1;
  logic [31:0] r_crc;
  logic [31:0] w_fcs;
  logic        r_crc_en_q;
  logic        r_pad_en_q;
  logic [7:0]  r_hold_d;        // byte accepted at the previous edge
  logic        r_hold_last;
  logic        w_accept;
  logic [7:0]  w_tx_d;
  logic        w_tx_en;
  logic        w_tx_er;
  logic        w_crc_upd;
  logic [7:0]  w_crc_byte;
  logic        w_cnt_inc;
  logic        w_underrun;
  logic        w_good_end;

  assign w_accept    = tx_ready & tx_valid;
  assign w_cnt_plus1 = (r_byte_cnt == c_BYTE_CNT_MAX) ? r_byte_cnt : r_byte_cnt + 16'd1;
  assign w_fcs       = ~r_crc;

  // Next-state, handshake and the byte to launch on the GMII registers
  always_comb begin
    w_next_state = r_state;
    tx_ready     = 1'b0;
    w_tx_d       = 8'h00;
    w_tx_en      = 1'b0;
    w_tx_er      = 1'b0;
    w_crc_upd    = 1'b0;
    w_crc_byte   = r_hold_d;
    w_cnt_inc    = 1'b0;
    w_underrun   = 1'b0;
    w_good_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) w_next_state = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        w_tx_en = 1'b1;
        w_tx_d  = c_PREAMBLE_BYTE;
        if (r_tick == c_PRE_LAST) w_next_state = ST_SFD;
      end
      ST_SFD: begin
        // First payload byte is taken at the end of the SFD cycle
        w_tx_en  = 1'b1;
        w_tx_d   = c_SFD_BYTE;
        tx_ready = 1'b1;
        w_next_state = tx_valid ? ST_PAYLOAD : ST_ABORT;
      end
      ST_PAYLOAD: begin
        // Emit the byte taken at the previous edge; accept the next one
        // unless that byte closed the frame
        w_tx_en   = 1'b1;
        w_tx_d    = r_hold_d;
        w_crc_upd = 1'b1;
        w_cnt_inc = 1'b1;
        if (r_hold_last) begin
          if (r_pad_en_q && (w_cnt_plus1 < c_MIN_FRAME)) begin
            w_next_state = ST_PAD;
          end else if (r_crc_en_q) begin
            w_next_state = ST_FCS;
          end else begin
            w_next_state = ST_IFG;
            w_good_end   = 1'b1;
          end
        end else begin
          tx_ready = 1'b1;
          if (!tx_valid) w_next_state = ST_ABORT;
        end
      end
      ST_PAD: begin
        w_tx_en    = 1'b1;
        w_crc_upd  = 1'b1;
        w_crc_byte = 8'h00;
        w_cnt_inc  = 1'b1;
        if (w_cnt_plus1 >= c_MIN_FRAME) begin
          if (r_crc_en_q) begin
            w_next_state = ST_FCS;
          end else begin
            w_next_state = ST_IFG;
            w_good_end   = 1'b1;
          end
        end
      end
      ST_FCS: begin
        w_tx_en = 1'b1;
        case (r_tick[1:0])
          2'd0:    w_tx_d = w_fcs[7:0];
          2'd1:    w_tx_d = w_fcs[15:8];
          2'd2:    w_tx_d = w_fcs[23:16];
          default: w_tx_d = w_fcs[31:24];
        endcase
        if (r_tick == c_FCS_LAST) begin
          w_next_state = ST_IFG;
          w_good_end   = 1'b1;
        end
      end
      ST_ABORT: begin
        w_tx_en      = 1'b1;
        w_tx_er      = 1'b1;
        w_underrun   = 1'b1;
        w_next_state = ST_IFG;
      end
      ST_IFG: begin
        if (r_tick == c_IFG_LAST) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register and per-state cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tick  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_tick  <= (w_next_state != r_state) ? 8'd0 : r_tick + 8'd1;
    end
  end

  // Per-frame context: options, running CRC, byte count, accepted byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc_en_q  <= 1'b0;
      r_pad_en_q  <= 1'b0;
      r_crc       <= 32'h00000000;
      r_byte_cnt  <= 16'd0;
      r_hold_d    <= 8'h00;
      r_hold_last <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_crc      <= c_CRC_INIT;
        r_byte_cnt <= 16'd0;
        if (tx_valid) begin
          r_crc_en_q <= crc_en;
          r_pad_en_q <= pad_en;
        end
      end else begin
        if (w_crc_upd) r_crc <= crc32_next(r_crc, w_crc_byte);
        if (w_cnt_inc) r_byte_cnt <= w_cnt_plus1;
      end
      if (w_accept) begin
        r_hold_d    <= tx_data;
        r_hold_last <= tx_last;
      end
    end
  end

  // Registered GMII pins, status pulses and good-frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gmii_tx_d  <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      gmii_tx_d  <= w_tx_d;
      gmii_tx_en <= w_tx_en;
      gmii_tx_er <= w_tx_er;
      frame_done <= w_good_end;
      underrun   <= w_underrun;
      if (w_good_end) frame_cnt <= frame_cnt + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmii_tx_framer
// Description : Scoreboard bench for gmii_tx_framer. Expected GMII bytes are
//               built from a frame-level model and queued at issue time; a
//               monitor pops and compares every byte with en high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

  localparam int PRE = 7;
  localparam int IFG = 12;
  localparam int MIN = 60;

  logic        clk;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic        crc_en;
  logic        pad_en;
  logic [7:0]  gmii_tx_d;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        frame_done;
  logic        underrun;
  logic [31:0] frame_cnt;

  gmii_tx_framer #(
    .PREAMBLE_LEN(PRE), .IFG_BYTES(IFG), .MIN_FRAME(MIN), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .crc_en(crc_en), .pad_en(pad_en),
    .gmii_tx_d(gmii_tx_d), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .frame_done(frame_done), .underrun(underrun), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];   // {er, d}
  int gap_q[$];           // >0 exact, <0 minimum, 0 unchecked
  int done_cnt = 0, und_cnt = 0, good_exp = 0, und_exp = 0;
  int low_run = 0, high_run = 0, last_high = 0;
  logic [7:0] pl [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected CRC-32 over a whole message, one bit at a time
  function automatic logic [31:0] ref_crc(input logic [7:0] msg[$]);
    logic [31:0] r;
    logic fb;
    r = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ msg[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return ~r;
  endfunction

  // mode 0: good frame, 1: underrun after 'cut' bytes, 2: cut by reset
  task automatic expect_frame(input int len, input bit crc, input bit pad,
                              input int mode, input int cut, input int gap);
    logic [7:0] body[$];
    logic [31:0] f;
    gap_q.push_back(gap);
    for (int k = 0; k < PRE; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (mode != 0) begin
      for (int k = 0; k < cut; k++) exp_q.push_back({1'b0, pl[k]});
      if (mode == 1) begin
        exp_q.push_back({1'b1, 8'h00});
        und_exp++;
      end
    end else begin
      for (int k = 0; k < len; k++) body.push_back(pl[k]);
      if (pad) while (body.size() < MIN) body.push_back(8'h00);
      foreach (body[k]) exp_q.push_back({1'b0, body[k]});
      if (crc) begin
        f = ref_crc(body);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
      end
      good_exp++;
    end
  endtask

  // Client driver; called and returns just after a falling edge
  task automatic send_frame(input int len, input bit crc, input bit pad,
                            input int mode, input int cut, input bit do_lat);
    int i, guard, nsend;
    bit rdy;
    i = 0; guard = 0;
    nsend = (mode == 0) ? len : cut;
    crc_en = crc; pad_en = pad;
    if (do_lat) begin
      tx_valid = 1'b1; tx_data = pl[0]; tx_last = (mode == 0) && (len == 1);
      @(negedge clk);
      check("latency_edge0_en", gmii_tx_en, 0);
      @(negedge clk);
      check("latency_edge1_en", gmii_tx_en, 1);
      check("latency_edge1_d", gmii_tx_d, 8'h55);
    end
    while (i < nsend && guard < 500) begin
      tx_valid = 1'b1; tx_data = pl[i]; tx_last = (mode == 0) && (i == len - 1);
      #1 rdy = tx_ready;
      @(posedge clk);
      if (rdy) i++;
      guard++;
      @(negedge clk);
      if (i > 0) begin crc_en = 1'($urandom); pad_en = 1'($urandom); end
    end
    if (i != nsend) check("send_accept_timeout", i, nsend);
    if (mode == 1) begin
      tx_valid = 1'b0; tx_last = 1'b1;
      @(negedge clk);
      tx_last = 1'b0;
    end
  endtask

  // Idle the client until the queued bytes are out, then check frame status
  task automatic drain(input bit chk_rdy);
    int n;
    bit rdy_seen;
    n = 0; rdy_seen = 1'b0;
    tx_valid = 1'b0;
    while ((exp_q.size() != 0 || gmii_tx_en) && n < 1000) begin
      @(negedge clk);
      tx_last = 1'($urandom); tx_data = 8'($urandom);
      if (tx_ready) rdy_seen = 1'b1;
      n++;
    end
    if (n >= 1000) check("drain_timeout_left", exp_q.size(), 0);
    if (chk_rdy) check("tx_ready_after_last", rdy_seen, 0);
    repeat (3) @(negedge clk);
    tx_last = 1'b0;
    check("frame_done_count", done_cnt, good_exp);
    check("underrun_count", und_cnt, und_exp);
    check("frame_cnt", frame_cnt, good_exp);
  endtask

  // Monitor: scoreboard pop on every enabled byte, gap and run tracking
  initial begin
    int g;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        low_run = 0; high_run = 0;
      end else begin
        if (frame_done) done_cnt++;
        if (underrun) und_cnt++;
        if (gmii_tx_en) begin
          if (high_run == 0) begin
            if (gap_q.size() > 0) begin
              g = gap_q.pop_front();
              if (g > 0) check("ifg_gap_exact", low_run, g);
              else if (g < 0) check("ifg_gap_min_ok", (low_run >= -g), 1);
            end
            low_run = 0;
          end
          high_run++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {gmii_tx_er, gmii_tx_d}, 9'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("gmii_byte_er_d", {gmii_tx_er, gmii_tx_d}, e);
          end
        end else begin
          if (high_run != 0) begin
            last_high = high_run;
            high_run  = 0;
          end
          low_run++;
          check("idle_er_d", {gmii_tx_er, gmii_tx_d}, 0);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_gap;
    reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    crc_en = 1'b0; pad_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", gmii_tx_en, 0);
    check("rst_er", gmii_tx_er, 0);
    check("rst_d", gmii_tx_d, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789" with FCS, latency from IDLE
    for (int k = 0; k < 9; k++) pl[k] = 8'h31 + 8'(k);
    expect_frame(9, 1, 0, 0, 0, 0);
    send_frame(9, 1, 0, 0, 0, 1);
    drain(0);
    check("en_run_crc_frame", last_high, 21);

    // Padded 10-byte frame, no FCS
    for (int k = 0; k < 10; k++) pl[k] = 8'($urandom);
    expect_frame(10, 0, 1, 0, 0, -(IFG + 1));
    send_frame(10, 0, 1, 0, 0, 0);
    drain(1);
    check("en_run_pad_frame", last_high, 68);

    // Underrun after 5 bytes, next frame waiting right behind it
    for (int k = 0; k < 20; k++) pl[k] = 8'($urandom);
    expect_frame(20, 1, 0, 1, 5, -(IFG + 1));
    send_frame(20, 1, 0, 1, 5, 0);
    for (int k = 0; k < 30; k++) pl[k] = 8'($urandom);
    expect_frame(30, 1, 1, 0, 0, IFG + 1);
    send_frame(30, 1, 1, 0, 0, 0);
    drain(0);

    // Randomized frames, some back-to-back, some underruns
    next_gap = -(IFG + 1);
    for (int r = 0; r < 12; r++) begin
      int len, mode, cut;
      bit c, p;
      len  = $urandom_range(2, 90);
      c    = 1'($urandom);
      p    = 1'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      cut  = $urandom_range(1, len - 1);
      for (int k = 0; k < len; k++) pl[k] = 8'($urandom);
      expect_frame(len, c, p, mode, cut, next_gap);
      send_frame(len, c, p, mode, cut, 0);
      if (mode == 1 || $urandom_range(0, 1) == 1) begin
        next_gap = IFG + 1;
      end else begin
        drain(0);
        next_gap = -(IFG + 1);
      end
    end
    drain(0);

    // Reset in the middle of payload byte 20
    for (int k = 0; k < 30; k++) pl[k] = 8'($urandom);
    expect_frame(30, 1, 0, 2, 20, -(IFG + 1));
    send_frame(30, 1, 0, 2, 20, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_en", gmii_tx_en, 0);
    check("midrst_er", gmii_tx_er, 0);
    check("midrst_ready", tx_ready, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    tx_valid = 1'b0; tx_last = 1'b0;
    exp_q.delete(); gap_q.delete();
    done_cnt = 0; und_cnt = 0; good_exp = 0; und_exp = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Two 64-byte frames with tx_valid held high between them
    for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
    expect_frame(64, 1, 0, 0, 0, 0);
    send_frame(64, 1, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
    expect_frame(64, 1, 0, 0, 0, IFG + 1);
    send_frame(64, 1, 0, 0, 0, 0);
    drain(0);
    check("b2b_frame_cnt_two", frame_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
